// File: rtl/alu_cmd_ctrl.sv
// Command controller in front of the ALU: parses CMD/A/B/FUNC frames from rx,
// pulses the ALU enable, and returns the 16-bit result on tx, low byte first.
module alu_cmd_ctrl #(
    parameter int                       DATA_IN_WIDTH  = 8,
    parameter int                       DATA_OUT_WIDTH = 2 * DATA_IN_WIDTH,
    parameter logic [DATA_IN_WIDTH-1:0] CMD_FULL       = 8'hCC,
    parameter logic [DATA_IN_WIDTH-1:0] CMD_REUSE      = 8'hDD,
    parameter int                       ALU_TIMEOUT    = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [DATA_IN_WIDTH-1:0]  rx_data_in,
    input  logic                      rx_valid_in,
    output logic [DATA_IN_WIDTH-1:0]  alu_a_out,
    output logic [DATA_IN_WIDTH-1:0]  alu_b_out,
    output logic [3:0]                alu_func_out,
    output logic                      alu_en_out,
    input  logic [DATA_OUT_WIDTH-1:0] alu_data_in,
    input  logic                      alu_valid_in,
    output logic [DATA_IN_WIDTH-1:0]  tx_data_out,
    output logic                      tx_valid_out,
    input  logic                      tx_busy_in,
    output logic                      rx_drop_out,
    output logic                      alu_err_out
);

    localparam int TW = $clog2(ALU_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_A,
        S_GET_B,
        S_GET_F,
        S_ALU_REQ,
        S_ALU_WAIT,
        S_TX_LO,
        S_TX_HI
    } state_t;

    state_t                    r_state;
    logic [DATA_IN_WIDTH-1:0]  r_a;
    logic [DATA_IN_WIDTH-1:0]  r_b;
    logic [3:0]                r_func;
    logic                      r_alu_en;
    logic                      r_alu_err;
    logic [TW-1:0]             r_wait_cnt;
    logic [DATA_OUT_WIDTH-1:0] r_result;
    logic [DATA_IN_WIDTH-1:0]  r_tx_data;
    logic                      r_tx_valid;
    logic                      w_busy_state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_func     <= '0;
            r_alu_en   <= 1'b0;
            r_alu_err  <= 1'b0;
            r_wait_cnt <= '0;
            r_result   <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
        end else begin
            r_alu_en  <= 1'b0;
            r_alu_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (rx_valid_in) begin
                        if (rx_data_in == CMD_FULL)
                            r_state <= S_GET_A;
                        else if (rx_data_in == CMD_REUSE)
                            r_state <= S_GET_F;
                    end
                end
                S_GET_A: begin
                    if (rx_valid_in) begin
                        r_a     <= rx_data_in;
                        r_state <= S_GET_B;
                    end
                end
                S_GET_B: begin
                    if (rx_valid_in) begin
                        r_b     <= rx_data_in;
                        r_state <= S_GET_F;
                    end
                end
                S_GET_F: begin
                    // Enable is registered so it is high exactly while in ALU_REQ.
                    if (rx_valid_in) begin
                        r_func   <= rx_data_in[3:0];
                        r_alu_en <= 1'b1;
                        r_state  <= S_ALU_REQ;
                    end
                end
                S_ALU_REQ: begin
                    r_wait_cnt <= '0;
                    r_state    <= S_ALU_WAIT;
                end
                S_ALU_WAIT: begin
                    if (alu_valid_in) begin
                        r_result   <= alu_data_in;
                        r_tx_data  <= alu_data_in[DATA_IN_WIDTH-1:0];
                        r_tx_valid <= 1'b1;
                        r_state    <= S_TX_LO;
                    end else if (r_wait_cnt == TW'(ALU_TIMEOUT - 1)) begin
                        r_alu_err <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_TX_LO: begin
                    if (!tx_busy_in) begin
                        r_tx_data <= r_result[DATA_OUT_WIDTH-1 -: DATA_IN_WIDTH];
                        r_state   <= S_TX_HI;
                    end
                end
                S_TX_HI: begin
                    if (!tx_busy_in) begin
                        r_tx_valid <= 1'b0;
                        r_tx_data  <= '0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Bytes arriving while a command is in flight are discarded, never buffered.
    always_comb begin
        w_busy_state = 1'b0;
        if (r_state inside {S_ALU_REQ, S_ALU_WAIT, S_TX_LO, S_TX_HI})
            w_busy_state = 1'b1;
    end

    assign rx_drop_out  = rx_valid_in & w_busy_state;
    assign alu_a_out    = r_a;
    assign alu_b_out    = r_b;
    assign alu_func_out = r_func;
    assign alu_en_out   = r_alu_en;
    assign alu_err_out  = r_alu_err;
    assign tx_data_out  = r_tx_data;
    assign tx_valid_out = r_tx_valid;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed plus randomized frames against a frame-level reference model;
// the bench also plays the role of the ALU and the transmitter.
module tb_alu_cmd_ctrl;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  rx_data_in;
    logic        rx_valid_in;
    logic [7:0]  alu_a_out;
    logic [7:0]  alu_b_out;
    logic [3:0]  alu_func_out;
    logic        alu_en_out;
    logic [15:0] alu_data_in;
    logic        alu_valid_in;
    logic [7:0]  tx_data_out;
    logic        tx_valid_out;
    logic        tx_busy_in;
    logic        rx_drop_out;
    logic        alu_err_out;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] m_a = 8'h00;
    logic [7:0] m_b = 8'h00;

    always #5 clk = ~clk;

    alu_cmd_ctrl #(
        .DATA_IN_WIDTH (8),
        .ALU_TIMEOUT   (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_data_in   (rx_data_in),
        .rx_valid_in  (rx_valid_in),
        .alu_a_out    (alu_a_out),
        .alu_b_out    (alu_b_out),
        .alu_func_out (alu_func_out),
        .alu_en_out   (alu_en_out),
        .alu_data_in  (alu_data_in),
        .alu_valid_in (alu_valid_in),
        .tx_data_out  (tx_data_out),
        .tx_valid_out (tx_valid_out),
        .tx_busy_in   (tx_busy_in),
        .rx_drop_out  (rx_drop_out),
        .alu_err_out  (alu_err_out)
    );

    function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] f);
        int ia = int'(a);
        int ib = int'(b);
        case (f)
            4'd0:    return 16'(ia + ib);
            4'd1:    return 16'(ia - ib);
            4'd2:    return 16'(ia * ib);
            default: return {a & b, a | b};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; presents one byte for one cycle.
    task automatic send_byte(input logic [7:0] b, input logic exp_drop);
        rx_valid_in = 1'b1;
        rx_data_in  = b;
        #1 chk("rx_drop", 16'(rx_drop_out), 16'(exp_drop));
        @(negedge clk);
        rx_valid_in = 1'b0;
    endtask

    task automatic check_all_zero();
        chk("rst_a", 16'(alu_a_out), 16'h0);
        chk("rst_b", 16'(alu_b_out), 16'h0);
        chk("rst_func", 16'(alu_func_out), 16'h0);
        chk("rst_en", 16'(alu_en_out), 16'h0);
        chk("rst_txv", 16'(tx_valid_out), 16'h0);
        chk("rst_txd", 16'(tx_data_out), 16'h0);
        chk("rst_drop", 16'(rx_drop_out), 16'h0);
        chk("rst_err", 16'(alu_err_out), 16'h0);
    endtask

    // w: ALU_WAIT cycle index on which the ALU answers (>= TIMEOUT means never).
    task automatic run_frame(input logic full, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] f, input int w, input int busy_lo,
                             input int busy_hi, input logic inj, input logic rst_hi);
        logic [15:0] exp;
        if (full) begin
            send_byte(8'hCC, 1'b0);
            send_byte(a, 1'b0);
            send_byte(b, 1'b0);
            m_a = a;
            m_b = b;
        end else begin
            send_byte(8'hDD, 1'b0);
        end
        send_byte(f, 1'b0);
        exp = alu_ref(m_a, m_b, f[3:0]);
        #1;
        chk("en_req", 16'(alu_en_out), 16'h1);
        chk("op_a", 16'(alu_a_out), 16'(m_a));
        chk("op_b", 16'(alu_b_out), 16'(m_b));
        chk("op_func", 16'(alu_func_out), 16'(f[3:0]));
        @(negedge clk);
        for (int k = 0; k < TIMEOUT; k++) begin
            chk("en_wait", 16'(alu_en_out), 16'h0);
            chk("txv_wait", 16'(tx_valid_out), 16'h0);
            chk("err_wait", 16'(alu_err_out), 16'h0);
            if (inj && k == 1) begin
                rx_valid_in = 1'b1;
                rx_data_in  = 8'($urandom);
                #1 chk("drop_wait", 16'(rx_drop_out), 16'h1);
            end
            if (k == w) begin
                alu_valid_in = 1'b1;
                alu_data_in  = exp;
            end
            @(negedge clk);
            rx_valid_in  = 1'b0;
            alu_valid_in = 1'b0;
            alu_data_in  = 16'($urandom);
            if (k == w) break;
        end
        if (w >= TIMEOUT) begin
            chk("err_pulse", 16'(alu_err_out), 16'h1);
            chk("txv_to", 16'(tx_valid_out), 16'h0);
            @(negedge clk);
            chk("err_clear", 16'(alu_err_out), 16'h0);
            chk("txv_to2", 16'(tx_valid_out), 16'h0);
            return;
        end
        tx_busy_in = (busy_lo > 0);
        for (int i = 0; i < busy_lo; i++) begin
            chk("txv_lo_busy", 16'(tx_valid_out), 16'h1);
            chk("txd_lo_busy", 16'(tx_data_out), 16'(exp[7:0]));
            if (inj && i == 0) begin
                rx_valid_in = 1'b1;
                rx_data_in  = 8'($urandom);
                #1 chk("drop_tx", 16'(rx_drop_out), 16'h1);
            end
            @(negedge clk);
            rx_valid_in = 1'b0;
        end
        tx_busy_in = 1'b0;
        chk("txv_lo", 16'(tx_valid_out), 16'h1);
        chk("txd_lo", 16'(tx_data_out), 16'(exp[7:0]));
        @(negedge clk);
        if (rst_hi) begin
            chk("txv_hi_pre_rst", 16'(tx_valid_out), 16'h1);
            reset_n = 1'b0;
            #1 check_all_zero();
            @(negedge clk);
            reset_n = 1'b1;
            m_a = 8'h00;
            m_b = 8'h00;
            return;
        end
        tx_busy_in = (busy_hi > 0);
        for (int i = 0; i < busy_hi; i++) begin
            chk("txv_hi_busy", 16'(tx_valid_out), 16'h1);
            chk("txd_hi_busy", 16'(tx_data_out), 16'(exp[15:8]));
            @(negedge clk);
        end
        tx_busy_in = 1'b0;
        chk("txv_hi", 16'(tx_valid_out), 16'h1);
        chk("txd_hi", 16'(tx_data_out), 16'(exp[15:8]));
        @(negedge clk);
        chk("txv_done", 16'(tx_valid_out), 16'h0);
    endtask

    initial begin
        logic [7:0] junk;
        int         w;
        reset_n      = 1'b0;
        rx_data_in   = '0;
        rx_valid_in  = 1'b0;
        alu_data_in  = '0;
        alu_valid_in = 1'b0;
        tx_busy_in   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all_zero();
        reset_n = 1'b1;
        @(negedge clk);

        // Reuse before any full frame: operands from reset, zero result still sent.
        run_frame(1'b0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1'b0, 1'b0);
        run_frame(1'b1, 8'h05, 8'h03, 8'h02, 0, 0, 0, 1'b0, 1'b0);
        run_frame(1'b0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1'b0, 1'b0);
        send_byte(8'h55, 1'b0);
        run_frame(1'b1, 8'hFF, 8'hFF, 8'h02, 0, 0, 0, 1'b0, 1'b0);
        run_frame(1'b1, 8'h12, 8'h34, 8'h00, 0, 10, 0, 1'b1, 1'b0);
        run_frame(1'b1, 8'h21, 8'h43, 8'h01, TIMEOUT, 0, 0, 1'b0, 1'b0);
        run_frame(1'b1, 8'h09, 8'h07, 8'h01, TIMEOUT - 1, 0, 0, 1'b0, 1'b0);
        run_frame(1'b1, 8'hA5, 8'h5A, 8'hF3, 1, 0, 2, 1'b0, 1'b1);
        run_frame(1'b1, 8'h02, 8'h02, 8'h00, 0, 0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                junk = 8'($urandom);
                if (junk == 8'hCC || junk == 8'hDD) junk = junk ^ 8'h01;
                send_byte(junk, 1'b0);
            end
            w = ($urandom_range(0, 4) == 0) ? TIMEOUT + $urandom_range(0, 1)
                                            : $urandom_range(0, TIMEOUT - 1);
            run_frame(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                      8'($urandom), w, $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_cmd_ctrl.md
Name: alu_cmd_ctrl

Overview:
Command controller that sits directly upstream of the ALU and also consumes its result. It parses a byte stream from the serial receive path into ALU operands and a function code, then issues a single-cycle enable to the ALU. It captures the registered 16-bit result and returns it to the serial transmit path as two bytes, low byte first, under a valid/busy handshake.

Parameters:
DATA_IN_WIDTH, 8, operand width and rx/tx byte width
DATA_OUT_WIDTH, 2*DATA_IN_WIDTH, ALU result width; always sent as exactly two tx bytes
CMD_FULL, 8'hCC, opcode for a full frame: CMD, A, B, FUNC
CMD_REUSE, 8'hDD, opcode for a short frame: CMD, FUNC; reuses the stored A and B
ALU_TIMEOUT, 4, maximum cycles to wait for alu_valid_in after alu_en_out

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
rx_data_in  in  DATA_IN_WIDTH  received byte
rx_valid_in  in  1  one-cycle pulse; rx_data_in is valid this cycle
alu_a_out  out  DATA_IN_WIDTH  operand A to the ALU (registered)
alu_b_out  out  DATA_IN_WIDTH  operand B to the ALU (registered)
alu_func_out  out  4  ALU function code (registered)
alu_en_out  out  1  one-cycle ALU enable
alu_data_in  in  DATA_OUT_WIDTH  registered ALU result
alu_valid_in  in  1  ALU result valid
tx_data_out  out  DATA_IN_WIDTH  byte to transmit
tx_valid_out  out  1  tx_data_out is valid
tx_busy_in  in  1  transmitter busy; a transfer completes only when this is low
rx_drop_out  out  1  one-cycle pulse: an rx byte was discarded
alu_err_out  out  1  one-cycle pulse: ALU response timed out

Behaviour:
- Reset: the async assert of reset_n drives every output and internal register to 0 and the FSM to IDLE. Deassertion is synchronised by the surrounding design. Reset mid-frame or mid-transmit abandons all work; no partial byte is resent.
- FSM states: IDLE, GET_A, GET_B, GET_F, ALU_REQ, ALU_WAIT, TX_LO, TX_HI.
- IDLE:
  - rx byte == CMD_FULL -> GET_A.
  - rx byte == CMD_REUSE -> GET_F.
  - Any other byte is ignored silently; no drop pulse.
- GET_A: on rx_valid_in, latch alu_a_out, go to GET_B.
- GET_B: on rx_valid_in, latch alu_b_out, go to GET_F.
- GET_F: on rx_valid_in, latch rx_data_in[3:0] into alu_func_out (upper bits ignored), go to ALU_REQ.
- No inter-byte timeout: the FSM waits indefinitely in the GET_* states.
- ALU_REQ: alu_en_out = 1 for exactly this one cycle, then go to ALU_WAIT. Operands and function are stable from the cycle after the FUNC byte until the next frame's latch.
- ALU_WAIT:
  - On alu_valid_in, capture alu_data_in into an internal result register and go to TX_LO.
  - The nominal response is the first ALU_WAIT cycle.
  - If alu_valid_in is not seen within ALU_TIMEOUT cycles, pulse alu_err_out for 1 cycle, go to IDLE, send no bytes.
- TX_LO and TX_HI:
  - tx_valid_out = 1 with tx_data_out = result[7:0] (TX_LO) or result[15:8] (TX_HI).
  - Data is held stable while tx_busy_in = 1.
  - A transfer occurs on a cycle where tx_valid_out = 1 and tx_busy_in = 0.
  - On transfer: TX_LO -> TX_HI; TX_HI -> IDLE with tx_valid_out = 0 the next cycle.
  - Zero results are still transmitted as two bytes.
- alu_en_out = 0 in every state except ALU_REQ. tx_valid_out = 0 outside TX_LO and TX_HI.
- rx_valid_in in ALU_REQ, ALU_WAIT, TX_LO or TX_HI: the byte is discarded and rx_drop_out pulses the same cycle. A byte is never buffered.
- Minimum latency: FUNC byte at cycle N -> alu_en_out at N+1 -> alu_valid_in at N+2 -> tx_valid_out at N+3.
- CMD_REUSE before any CMD_FULL uses the reset operands A = 0, B = 0.

Test Plan:
- rx CC,05,03,02 -> alu_en_out 1 cycle with A=05, B=03, F=2; ALU model returns 000F -> tx bytes 0F then 00.
- After the first test, rx DD,00 -> alu_en_out with A=05, B=03, F=0; result 0008 -> tx bytes 08, 00.
- rx 55, then CC,FF,FF,02 -> 55 ignored with no rx_drop_out; result FE01 -> tx bytes 01, FE.
- Hold tx_busy_in = 1 for 10 cycles during TX_LO -> tx_valid_out stays 1 with tx_data_out stable; one byte transferred after release; rx byte sent meanwhile -> rx_drop_out pulse, state unchanged.
- ALU model never asserts valid -> alu_err_out pulses 1 cycle after 4 wait cycles, FSM returns to IDLE, no tx_valid_out.
- reset_n low during TX_HI -> all outputs 0 immediately; the next frame CC,02,02,00 operates normally (tx 04, 00).
